axi4_write_scheduler: RTL and testbench

//  Shares one AXI4-Lite write channel (AW/W/B) between NUM_REQ on-chip requesters, e.g. neuron cores

---
 rtl/axi4_write_scheduler_pkg.sv | 17 +
 rtl/axi4_write_scheduler_if.sv | 52 +++++
 rtl/axi4_write_scheduler_rr_arbiter.sv | 32 +++
 rtl/axi4_write_scheduler.sv | 174 +++++++++++++++++
 tb/tb_axi4_write_scheduler.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_write_scheduler_pkg.sv
// Shared types for the AXI4-Lite write scheduler: response codes and FSM state encoding.
package axi4_write_scheduler_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/axi4_write_scheduler_if.sv
// Requester-side and AXI4-Lite write-channel signals of the scheduler, bundled in one interface.
interface axi4_write_scheduler_if
    import axi4_write_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) ();

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*ADDR_W-1:0]   req_addr;
    logic [NUM_REQ*DATA_W-1:0]   req_data;
    logic [NUM_REQ*DATA_W/8-1:0] req_strb;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ-1:0]          req_done;
    resp_t                       req_resp;

    logic [ADDR_W-1:0]           awaddr;
    logic                        awvalid;
    logic                        awready;
    logic [DATA_W-1:0]           wdata;
    logic [DATA_W/8-1:0]         wstrb;
    logic                        wvalid;
    logic                        wready;
    resp_t                       bresp;
    logic                        bvalid;
    logic                        bready;

    logic                        busy;
    logic                        timeout_err;

    // Scheduler view: consumes requests, masters the AXI write channel.
    modport master (
        input  req_valid, req_addr, req_data, req_strb,
        output req_ready, req_done, req_resp,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output busy, timeout_err
    );

    // Environment view: requesters plus the AXI slave.
    modport slave (
        output req_valid, req_addr, req_data, req_strb,
        input  req_ready, req_done, req_resp,
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  busy, timeout_err
    );

endinterface

// File: rtl/axi4_write_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester set after rr_ptr_i, wrapping modulo NUM_REQ.
module axi4_write_scheduler_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    assign any_o = |req_i;

    // Scan from the farthest offset down so the nearest one after the pointer wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        idx_o = '0;
        cand  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(rr_ptr_i) + k) % NUM_REQ);
            if (req_i[cand]) begin
                idx_o = cand;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
        assign grant_o[gi] = any_o && (idx_o == IDX_W'(gi));
    end

endmodule

// File: rtl/axi4_write_scheduler.sv
// Round-robin scheduler sharing one AXI4-Lite write channel between NUM_REQ requesters,
// one AW/W/B transaction in flight, with a sticky watchdog flag.
module axi4_write_scheduler
    import axi4_write_scheduler_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    axi4_write_scheduler_if.master bus
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(TIMEOUT_CYC);
    // cnt_q lags the cycles-since-grant count by one, hence the trip point at TIMEOUT_CYC-2.
    localparam logic [CNT_W-1:0]   CNT_TRIP = CNT_W'(TIMEOUT_CYC - 2);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [DATA_W-1:0] data_arr [NUM_REQ];
    logic [STRB_W-1:0] strb_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
        assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
        assign strb_arr[gi] = bus.req_strb[gi*STRB_W +: STRB_W];
    end

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [STRB_W-1:0]    strb_q, strb_d;
    logic                 aw_done_q, aw_done_d;
    logic                 w_done_q, w_done_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    resp_t                resp_q, resp_d;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;
    logic                 grant_en;
    logic                 awvalid_int, wvalid_int;
    logic                 aw_fire, w_fire;

    axi4_write_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i    (bus.req_valid),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (arb_grant),
        .idx_o    (arb_idx),
        .any_o    (arb_any)
    );

    assign awvalid_int = (state_q == ST_XFER) && !aw_done_q;
    assign wvalid_int  = (state_q == ST_XFER) && !w_done_q;
    assign aw_fire     = awvalid_int && bus.awready;
    assign w_fire      = wvalid_int && bus.wready;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        done_d    = '0;
        resp_d    = resp_q;
        grant_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // No grant while a done pulse is out, so the finished requester sees its
                // response before it can compete again.
                if (arb_any && (done_q == '0)) begin
                    grant_en  = 1'b1;
                    state_d   = ST_XFER;
                    idx_d     = arb_idx;
                    addr_d    = addr_arr[arb_idx];
                    data_d    = data_arr[arb_idx];
                    strb_d    = strb_arr[arb_idx];
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    cnt_d     = '0;
                end
            end
            ST_XFER: begin
                aw_done_d = aw_done_q || aw_fire;
                w_done_d  = w_done_q || w_fire;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.bvalid) begin
                    state_d  = ST_IDLE;
                    done_d   = ONE_HOT0 << idx_q;
                    resp_d   = bus.bresp;
                    rr_ptr_d = idx_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_q != ST_IDLE) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (cnt_q == CNT_TRIP) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= IDX_W'(NUM_REQ - 1);
            idx_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            done_q    <= '0;
            resp_q    <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            done_q    <= done_d;
            resp_q    <= resp_d;
        end
    end

    // The grant is combinational; it is masked during reset so no payload is claimed then.
    assign bus.req_ready   = (grant_en && !reset) ? arb_grant : '0;
    assign bus.req_done    = done_q;
    assign bus.req_resp    = resp_q;
    assign bus.awaddr      = addr_q;
    assign bus.awvalid     = awvalid_int;
    assign bus.wdata       = data_q;
    assign bus.wstrb       = strb_q;
    assign bus.wvalid      = wvalid_int;
    assign bus.bready      = (state_q == ST_RESP);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_axi4_write_scheduler.sv
// Directed and randomized bench for axi4_write_scheduler with a transaction-level reference model.
module tb_axi4_write_scheduler;
    import axi4_write_scheduler_pkg::*;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axi4_write_scheduler_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    axi4_write_scheduler #(
        .NUM_REQ     (NR),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Requester drive
    logic [NR-1:0] vmask;
    logic [AW-1:0] addr_a [NR];
    logic [DW-1:0] data_a [NR];
    logic [SW-1:0] strb_a [NR];

    assign bus.req_valid = vmask;
    always_comb begin
        bus.req_addr = '0;
        bus.req_data = '0;
        bus.req_strb = '0;
        for (int i = 0; i < NR; i++) begin
            bus.req_addr[i*AW +: AW] = addr_a[i];
            bus.req_data[i*DW +: DW] = data_a[i];
            bus.req_strb[i*SW +: SW] = strb_a[i];
        end
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int txn = 0;

    // Slave configuration and observations
    int aw_wait, w_wait, b_wait;
    logic [1:0] b_rsp;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    int aw_cycles, w_cycles, b_start;
    logic aw_stable, w_stable;
    logic [AW-1:0] first_addr, cap_addr;
    logic [DW-1:0] first_data, cap_data;
    logic [SW-1:0] first_strb, cap_strb;
    int to_rise = -1;

    // Reference model state
    int m_rr, m_last_done, last_w, last_g;
    logic m_to;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic slave_step();
        if (bus.awvalid === 1'b1) begin
            if (aw_cnt == 0) first_addr = bus.awaddr;
            else if (bus.awaddr !== first_addr) aw_stable = 1'b0;
            bus.awready = (aw_cnt == aw_wait);
            if (aw_cnt == aw_wait) cap_addr = bus.awaddr;
            aw_cnt++;
            aw_cycles++;
        end else begin
            bus.awready = 1'b0;
            aw_cnt = 0;
        end
        if (bus.wvalid === 1'b1) begin
            if (w_cnt == 0) begin
                first_data = bus.wdata;
                first_strb = bus.wstrb;
            end else if (bus.wdata !== first_data || bus.wstrb !== first_strb) begin
                w_stable = 1'b0;
            end
            bus.wready = (w_cnt == w_wait);
            if (w_cnt == w_wait) begin
                cap_data = bus.wdata;
                cap_strb = bus.wstrb;
            end
            w_cnt++;
            w_cycles++;
        end else begin
            bus.wready = 1'b0;
            w_cnt = 0;
        end
        if (bus.bready === 1'b1) begin
            if (b_cnt == 0) b_start = cyc;
            bus.bvalid = (b_cnt == b_wait);
            bus.bresp  = (b_cnt == b_wait) ? b_rsp : 2'b00;
            b_cnt++;
        end else begin
            bus.bvalid = 1'b0;
            bus.bresp  = 2'b00;
            b_cnt = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        slave_step();
        if (bus.timeout_err === 1'b1 && to_rise < 0) to_rise = cyc;
    endtask

    task automatic clear_obs();
        aw_cycles = 0;
        w_cycles  = 0;
        b_start   = -1;
        aw_stable = 1'b1;
        w_stable  = 1'b1;
        cap_addr  = '0;
        cap_data  = '0;
        cap_strb  = '0;
    endtask

    task automatic model_reset();
        m_rr = NR - 1;
        m_last_done = -100;
        m_to = 1'b0;
        to_rise = -1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        vmask = '0;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    // One full transaction: predict winner and timing, then compare everything observed.
    task automatic run_one(input int aww, input int ww, input int bw, input logic [1:0] rsp,
                           input bit hold);
        int w, g, d, n, mx, exp_g, exp_d, c;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [SW-1:0] es;
        w = -1;
        for (int k = 1; k <= NR; k++) begin
            c = (m_rr + k) % NR;
            if (vmask[c[1:0]] && w < 0) w = c;
        end
        if (w < 0) w = 0;
        aw_wait = aww;
        w_wait  = ww;
        b_wait  = bw;
        b_rsp   = rsp;
        clear_obs();
        exp_g = (cyc > m_last_done) ? cyc : m_last_done + 1;
        ea = addr_a[w[1:0]];
        ed = data_a[w[1:0]];
        es = strb_a[w[1:0]];

        n = 0;
        #1;
        while (bus.req_ready == '0 && n < 50) begin
            tick();
            #1;
            n++;
        end
        check("grant_seen", 64'(n < 50), 64'(1));
        g = cyc;
        check("grant_vec", 64'(bus.req_ready), 64'(4'b0001 << w));
        check("grant_cycle", 64'(g), 64'(exp_g));
        check("busy_at_grant", 64'(bus.busy), 64'(0));

        tick();
        if (!hold) vmask[w[1:0]] = 1'b0;
        check("busy_xfer", 64'(bus.busy), 64'(1));
        check("awvalid_first", 64'(bus.awvalid), 64'(1));

        n = 0;
        while (bus.req_done == '0 && n < 64) begin
            tick();
            n++;
        end
        check("done_seen", 64'(n < 64), 64'(1));
        d = cyc;
        mx = (aww > ww) ? aww : ww;
        exp_d = g + 3 + mx + bw;
        check("done_cycle", 64'(d), 64'(exp_d));
        check("done_vec", 64'(bus.req_done), 64'(4'b0001 << w));
        check("done_resp", 64'(bus.req_resp), 64'(rsp));
        check("busy_at_done", 64'(bus.busy), 64'(0));
        check("awaddr", 64'(cap_addr), 64'(ea));
        check("wdata", 64'(cap_data), 64'(ed));
        check("wstrb", 64'(cap_strb), 64'(es));
        check("aw_cycles", 64'(aw_cycles), 64'(aww + 1));
        check("w_cycles", 64'(w_cycles), 64'(ww + 1));
        check("aw_stable", 64'(aw_stable), 64'(1));
        check("w_stable", 64'(w_stable), 64'(1));
        check("resp_entry", 64'(b_start), 64'(g + 2 + mx));
        if (!m_to && (d - g) >= TO) begin
            check("timeout_rise", 64'(to_rise), 64'(g + TO));
            m_to = 1'b1;
        end
        check("timeout_flag", 64'(bus.timeout_err), 64'(m_to));

        m_rr = w;
        m_last_done = d;
        last_w = w;
        last_g = g;
        $display("txn %0d: req=%0d grant@%0d done@%0d aw_wait=%0d w_wait=%0d b_wait=%0d resp=%0b",
                 txn, w, g, d, aww, ww, bw, rsp);
        txn++;
    endtask

    initial begin
        int n, prev_g;
        logic [NR-1:0] nm;
        reset = 1'b1;
        vmask = '0;
        for (int i = 0; i < NR; i++) begin
            addr_a[i] = '0;
            data_a[i] = '0;
            strb_a[i] = '0;
        end
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bresp   = 2'b00;
        aw_wait = 0; w_wait = 0; b_wait = 0; b_rsp = 2'b00;
        clear_obs();
        model_reset();
        repeat (3) tick();

        // Reset state
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_awvalid", 64'(bus.awvalid), 64'(0));
        check("rst_wvalid", 64'(bus.wvalid), 64'(0));
        check("rst_bready", 64'(bus.bready), 64'(0));
        check("rst_req_ready", 64'(bus.req_ready), 64'(0));
        check("rst_req_done", 64'(bus.req_done), 64'(0));
        check("rst_timeout", 64'(bus.timeout_err), 64'(0));
        reset = 1'b0;

        // Single requester, zero-wait slave
        addr_a[0] = 32'h0000_0100;
        data_a[0] = 32'hDEAD_BEEF;
        strb_a[0] = 4'hF;
        vmask = 4'b0001;
        run_one(0, 0, 0, RESP_OKAY, 1'b0);
        check("t1_winner", 64'(last_w), 64'(0));

        // All four held: fair rotation, 4 cycles per grant
        do_reset();
        for (int i = 0; i < NR; i++) begin
            addr_a[i] = 32'h1000 + 32'(i * 16);
            data_a[i] = 32'hA5A5_0000 + 32'(i);
            strb_a[i] = 4'(i + 3);
        end
        vmask = 4'b1111;
        prev_g = 0;
        for (int i = 0; i < 5; i++) begin
            run_one(0, 0, 0, RESP_OKAY, 1'b1);
            check("t2_order", 64'(last_w), 64'(i % NR));
            if (i > 0) check("t2_gap", 64'(last_g - prev_g), 64'(4));
            prev_g = last_g;
        end

        // AW delayed by 2 cycles, W immediate
        vmask = 4'b0010;
        addr_a[1] = 32'hCAFE_0040;
        run_one(2, 0, 0, RESP_OKAY, 1'b0);
        check("t3_aw_cycles", 64'(aw_cycles), 64'(3));
        check("t3_w_cycles", 64'(w_cycles), 64'(1));
        check("t3_resp_entry", 64'(b_start), 64'(last_g + 4));

        // SLVERR for requester 2, then requester 3 next
        vmask = 4'b1100;
        run_one(0, 0, 0, RESP_SLVERR, 1'b0);
        check("t4_winner", 64'(last_w), 64'(2));
        run_one(1, 0, 1, RESP_OKAY, 1'b0);
        check("t4_next", 64'(last_w), 64'(3));

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            nm = 4'($urandom_range(0, 15));
            for (int i = 0; i < NR; i++) begin
                if (nm[i] && !vmask[i]) begin
                    addr_a[i] = $urandom;
                    data_a[i] = $urandom;
                    strb_a[i] = 4'($urandom_range(0, 15));
                end
            end
            vmask = vmask | nm;
            if ($urandom_range(0, 7) == 0) vmask = vmask & ~(4'($urandom_range(0, 15)));
            if (vmask == '0) vmask = 4'b0001 << $urandom_range(0, 3);
            run_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 4)), 2'($urandom_range(0, 3)), 1'b0);
        end

        // Reset during RESP abandons the transaction
        vmask = 4'b0001;
        aw_wait = 0; w_wait = 0; b_wait = 10; b_rsp = RESP_OKAY;
        clear_obs();
        n = 0;
        #1;
        while (bus.req_ready == '0 && n < 50) begin
            tick();
            #1;
            n++;
        end
        check("t5_grant_seen", 64'(n < 50), 64'(1));
        tick();
        vmask = '0;
        n = 0;
        while (bus.bready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("t5_resp_seen", 64'(n < 20), 64'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        check("t5_busy", 64'(bus.busy), 64'(0));
        check("t5_bready", 64'(bus.bready), 64'(0));
        check("t5_awvalid", 64'(bus.awvalid), 64'(0));
        check("t5_done", 64'(bus.req_done), 64'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_done", 64'(bus.req_done), 64'(0));
        end
        vmask = 4'b1111;
        run_one(0, 0, 0, RESP_OKAY, 1'b0);
        check("t5_first_after_reset", 64'(last_w), 64'(0));

        // Watchdog: bvalid withheld 20 cycles
        vmask = 4'b0001;
        run_one(0, 0, 18, RESP_OKAY, 1'b0);
        check("t6_timeout_rise", 64'(to_rise), 64'(last_g + TO));
        repeat (3) tick();
        check("t6_timeout_sticky", 64'(bus.timeout_err), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
